plcp_frame_tx: RTL and testbench

Serial 802.11a PLCP frame transmitter, one bit per Clock. On a start request it emits, in order:
- the 96-bit preamble;
- the SIGNAL field;
- the scrambled SERVICE and PSDU bits, with PSDU bits pulled one at a time from an upstream source;
- the DATA tail.

It is the transmit-side counterpart of the frame receiver/descrambler path. Its bit stream is exactly what that path detects, parses and descrambles.

---
 rtl/plcp_frame_tx_if.sv | 22 ++
 rtl/plcp_frame_tx.sv | 156 +++++++++++++++
 tb/tb_plcp_frame_tx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/plcp_frame_tx_if.sv
// Bundles the frame request, PSDU pull handshake and serial output of plcp_frame_tx.
interface plcp_frame_tx_if;
  logic        Start;
  logic [3:0]  Rate;
  logic [11:0] Length;
  logic [6:0]  Seed;
  logic        Data_In;
  logic        Data_Req;
  logic        Output;
  logic        Busy;
  logic        Done;

  modport master (
    output Start, Rate, Length, Seed, Data_In,
    input  Data_Req, Output, Busy, Done
  );

  modport slave (
    input  Start, Rate, Length, Seed, Data_In,
    output Data_Req, Output, Busy, Done
  );
endinterface

// File: rtl/plcp_frame_tx.sv
// Serial 802.11a PLCP frame transmitter: preamble, SIGNAL, scrambled SERVICE/PSDU, tail.
module plcp_frame_tx #(
  parameter int unsigned PREAMBLE_BITS = 96
) (
  input logic           Clock,
  input logic           Reset,
  plcp_frame_tx_if.slave tx
);

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, SIG_RATE, SIG_RESERVED, SIG_LENGTH, SIG_PARITY,
    SIG_TAIL, DATA_SERVICE, DATA_PSDU, DATA_TAIL, FINISH
  } state_t;

  // state_q names the field of the bit that the next edge will load into Output
  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [14:0] psdu_q, psdu_d;
  logic [6:0]  scr_q, scr_d;
  logic [3:0]  rate_q, rate_d;
  logic [11:0] len_q, len_d;
  logic        out_q, out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fb;
  logic [14:0] psdu_last;

  assign fb        = scr_q[6] ^ scr_q[3];
  assign psdu_last = {len_q, 3'b000} - 15'd1;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      psdu_q  <= '0;
      scr_q   <= '0;
      rate_q  <= '0;
      len_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      psdu_q  <= psdu_d;
      scr_q   <= scr_d;
      rate_q  <= rate_d;
      len_q   <= len_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 7'd1;
    psdu_d  = psdu_q;
    scr_d   = scr_q;
    rate_d  = rate_q;
    len_d   = len_q;
    out_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tx.Start) begin
          // Accepting edge already emits preamble bit 0, so counting resumes at 1
          rate_d  = tx.Rate;
          len_d   = tx.Length;
          scr_d   = (tx.Seed == 7'd0) ? 7'h7F : tx.Seed;
          out_d   = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = 7'd1;
          state_d = PREAMBLE;
        end
      end
      PREAMBLE: begin
        out_d = ~cnt_q[0];
        if (cnt_q == 7'(PREAMBLE_BITS - 1)) begin
          cnt_d   = '0;
          state_d = SIG_RATE;
        end
      end
      SIG_RATE: begin
        out_d = rate_q[2'd3 - cnt_q[1:0]];
        if (cnt_q == 7'd3) begin
          cnt_d   = '0;
          state_d = SIG_RESERVED;
        end
      end
      SIG_RESERVED: begin
        cnt_d   = '0;
        state_d = SIG_LENGTH;
      end
      SIG_LENGTH: begin
        out_d = len_q[4'd11 - cnt_q[3:0]];
        if (cnt_q == 7'd11) begin
          cnt_d   = '0;
          state_d = SIG_PARITY;
        end
      end
      SIG_PARITY: begin
        out_d   = ^{rate_q, len_q};
        cnt_d   = '0;
        state_d = SIG_TAIL;
      end
      SIG_TAIL: begin
        if (cnt_q == 7'd5) begin
          cnt_d   = '0;
          state_d = DATA_SERVICE;
        end
      end
      DATA_SERVICE: begin
        out_d = fb;
        scr_d = {scr_q[5:0], fb};
        if (cnt_q == 7'd15) begin
          cnt_d   = '0;
          psdu_d  = '0;
          state_d = (len_q == 12'd0) ? DATA_TAIL : DATA_PSDU;
        end
      end
      DATA_PSDU: begin
        out_d  = tx.Data_In ^ fb;
        scr_d  = {scr_q[5:0], fb};
        cnt_d  = '0;
        psdu_d = psdu_q + 15'd1;
        if (psdu_q == psdu_last) state_d = DATA_TAIL;
      end
      DATA_TAIL: begin
        if (cnt_q == 7'd5) begin
          cnt_d   = '0;
          state_d = FINISH;
        end
      end
      FINISH: begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign tx.Data_Req = (state_q == DATA_PSDU);
  assign tx.Output   = out_q;
  assign tx.Busy     = busy_q;
  assign tx.Done     = done_q;

endmodule

// File: tb/tb_plcp_frame_tx.sv
// Directed bench for plcp_frame_tx: a bit-list frame model checked against Output every cycle.
module tb_plcp_frame_tx;

  logic Clock = 1'b0;
  logic Reset;

  plcp_frame_tx_if tx ();

  plcp_frame_tx #(.PREAMBLE_BITS(96)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .tx    (tx)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  bit psdu_bits[$];
  int req_idx = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // PSDU source: supply the next bit during every cycle the DUT requests one
  always @(negedge Clock) begin
    if (tx.Data_Req === 1'b1) begin
      tx.Data_In = (req_idx < psdu_bits.size()) ? psdu_bits[req_idx] : 1'b0;
      req_idx++;
    end
  end

  task automatic set_psdu(input int len, input logic [7:0] b0, input logic [7:0] b1, input bit rnd);
    logic [7:0] b;
    psdu_bits.delete();
    for (int i = 0; i < len; i++) begin
      b = rnd ? 8'($urandom) : ((i == 0) ? b0 : b1);
      for (int k = 0; k < 8; k++) psdu_bits.push_back(b[k]);
    end
  endtask

  // Frame as a flat bit list: field by field, scrambler as a 7-stage shift list S1..S7
  task automatic build_model(input logic [3:0] rate, input logic [11:0] len, input logic [6:0] seed);
    bit s[1:7];
    bit f, din, par;
    logic [6:0] sd;
    exp_q.delete();
    for (int i = 0; i < 96; i++) exp_q.push_back(i % 2 == 0);
    for (int i = 3; i >= 0; i--) exp_q.push_back(rate[i]);
    exp_q.push_back(1'b0);
    for (int i = 11; i >= 0; i--) exp_q.push_back(len[i]);
    par = 1'b0;
    for (int i = 0; i < 4; i++) par ^= rate[i];
    for (int i = 0; i < 12; i++) par ^= len[i];
    exp_q.push_back(par);
    for (int i = 0; i < 6; i++) exp_q.push_back(1'b0);
    sd = (seed == 7'd0) ? 7'h7F : seed;
    for (int i = 1; i <= 7; i++) s[i] = sd[i-1];
    for (int k = 0; k < 16 + 8 * int'(len); k++) begin
      din = (k < 16) ? 1'b0 : psdu_bits[k-16];
      f = s[7] ^ s[4];
      exp_q.push_back(din ^ f);
      for (int i = 7; i > 1; i--) s[i] = s[i-1];
      s[1] = f;
    end
    for (int i = 0; i < 6; i++) exp_q.push_back(1'b0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock); #1;
      check("idle_output", tx.Output, 1'b0);
      check("idle_busy", tx.Busy, 1'b0);
      check("idle_done", tx.Done, 1'b0);
    end
  endtask

  task automatic run_frame(input logic [3:0] rate, input logic [11:0] len,
                           input logic [6:0] seed, input int abort_at);
    int  nbits;
    bit  req_exp;
    build_model(rate, len, seed);
    nbits   = exp_q.size();
    req_idx = 0;
    @(negedge Clock);
    tx.Start = 1'b1; tx.Rate = rate; tx.Length = len; tx.Seed = seed;
    @(posedge Clock); #1;
    tx.Start = 1'b0; tx.Rate = ~rate; tx.Length = ~len; tx.Seed = ~seed;
    check("bit0", tx.Output, exp_q[0]);
    check("busy_rise", tx.Busy, 1'b1);
    for (int n = 1; n < nbits; n++) begin
      @(negedge Clock);
      req_exp = (n >= 136) && (n < 136 + 8 * int'(len));
      check("data_req", tx.Data_Req, req_exp);
      tx.Start = (n == 50);
      @(posedge Clock);
      if (n == abort_at) begin
        #2 Reset = 1'b1;
        #1;
        check("abort_output", tx.Output, 1'b0);
        check("abort_busy", tx.Busy, 1'b0);
        check("abort_done", tx.Done, 1'b0);
        check("abort_req", tx.Data_Req, 1'b0);
        return;
      end
      #1;
      check("frame_bit", tx.Output, exp_q[n]);
      check("busy_hold", tx.Busy, 1'b1);
      check("done_low", tx.Done, 1'b0);
    end
    @(negedge Clock);
    check("req_after", tx.Data_Req, 1'b0);
    @(posedge Clock); #1;
    check("end_output", tx.Output, 1'b0);
    check("end_busy", tx.Busy, 1'b0);
    check("end_done", tx.Done, 1'b1);
    check("req_count", req_idx, 8 * int'(len));
  endtask

  initial begin : stim
    logic [39:0] sig40;
    logic [15:0] svc;
    Reset = 1'b1;
    tx.Start = 1'b0; tx.Rate = '0; tx.Length = '0; tx.Seed = '0; tx.Data_In = 1'b0;
    #1;
    check("rst_output", tx.Output, 1'b0);
    check("rst_busy", tx.Busy, 1'b0);
    check("rst_done", tx.Done, 1'b0);
    check("rst_req", tx.Data_Req, 1'b0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    idle_cycles(3);

    // Frame A: SIGNAL and SERVICE pinned against hand-derived literals
    set_psdu(16, 8'h00, 8'h00, 1'b1);
    build_model(4'b1101, 12'h010, 7'h7F);
    for (int i = 0; i < 40; i++) sig40[39-i] = exp_q[96+i];
    check("model_sig_service", sig40, 40'b1101_0_000000010000_0_000000_0000111011110010);
    check("model_len_a", exp_q.size(), 270);
    run_frame(4'b1101, 12'h010, 7'h7F, -1);

    // Frame B back-to-back: Start is asserted in the Done cycle of frame A
    set_psdu(17, 8'h00, 8'h00, 1'b1);
    build_model(4'b1101, 12'h011, 7'h25);
    check("model_parity_b", exp_q[113], 1'b1);
    check("model_len_b", exp_q.size(), 278);
    run_frame(4'b1101, 12'h011, 7'h25, -1);
    idle_cycles(4);

    // Frame C: empty PSDU, zero seed acts as all-ones
    set_psdu(0, 8'h00, 8'h00, 1'b0);
    build_model(4'b0110, 12'h000, 7'h00);
    for (int i = 0; i < 16; i++) svc[15-i] = exp_q[120+i];
    check("model_service_c", svc, 16'b0000111011110010);
    check("model_len_c", exp_q.size(), 142);
    run_frame(4'b0110, 12'h000, 7'h00, -1);
    idle_cycles(2);

    // Frame D: known PSDU bytes A5 3C
    set_psdu(2, 8'hA5, 8'h3C, 1'b0);
    run_frame(4'b1011, 12'h002, 7'h5A, -1);

    // Frame E: Rate 0, single octet, seed 1
    set_psdu(1, 8'h00, 8'h00, 1'b1);
    run_frame(4'b0000, 12'h001, 7'h01, -1);
    idle_cycles(1);

    // Reset mid-frame, Start pulsed while in reset, then a clean frame
    set_psdu(3, 8'h00, 8'h00, 1'b1);
    run_frame(4'b1111, 12'h003, 7'h33, 130);
    @(negedge Clock); tx.Start = 1'b1;
    @(negedge Clock); tx.Start = 1'b0;
    check("rst_hold_output", tx.Output, 1'b0);
    check("rst_hold_busy", tx.Busy, 1'b0);
    Reset = 1'b0;
    idle_cycles(5);
    set_psdu(3, 8'h00, 8'h00, 1'b1);
    run_frame(4'b1111, 12'h003, 7'h33, -1);
    idle_cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
